// File: rtl/bp_pkg.sv
// Shared constants and counter arithmetic for the branch direction predictor.
// Counter helpers work on a 4-bit container so one function serves CTR_W = 2..4.
package bp_pkg;

    localparam int MIN_CTR_W = 2;
    localparam int MAX_CTR_W = 4;

    // Named states of a 2-bit counter.
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef logic [MAX_CTR_W-1:0] ctr_t;

    // Weakly-not-taken: the value just below the taken threshold.
    function automatic ctr_t ctr_reset(input int ctr_w);
        return ctr_t'((1 << (ctr_w - 1)) - 1);
    endfunction

    function automatic ctr_t sat_step(input ctr_t ctr, input logic taken, input int ctr_w);
        int max_val;
        max_val = (1 << ctr_w) - 1;
        if (taken) begin
            return (int'(ctr) < max_val) ? ctr + ctr_t'(1) : ctr;
        end
        return (ctr != '0) ? ctr - ctr_t'(1) : ctr;
    endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Table of saturating direction counters: one combinational read port and one
// write port; a read hitting the index being written sees the post-update value.
module bp_counter_table
    import bp_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int CTR_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic               i_wr_taken,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic               o_rd_taken
);

    localparam int               DEPTH    = 1 << INDEX_W;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_reset(CTR_W));

    logic [CTR_W-1:0] w_ctr [DEPTH];
    logic [CTR_W-1:0] w_wr_cur;
    logic [CTR_W-1:0] w_wr_next;
    logic [CTR_W-1:0] w_rd_ctr;
    logic             w_bypass;

    assign w_wr_cur  = w_ctr[i_wr_idx];
    assign w_wr_next = CTR_W'(sat_step(ctr_t'(w_wr_cur), i_wr_taken, CTR_W));

    // Each entry is its own flop group so the whole table clears on rst_n.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [CTR_W-1:0] r_ctr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ctr <= CTR_INIT;
                end else if (i_wr_en && (i_wr_idx == INDEX_W'(gi))) begin
                    r_ctr <= w_wr_next;
                end
            end

            assign w_ctr[gi] = r_ctr;
        end
    endgenerate

    assign w_bypass   = i_wr_en && (i_wr_idx == i_rd_idx);
    assign w_rd_ctr   = w_bypass ? w_wr_next : w_ctr[i_rd_idx];
    assign o_rd_taken = w_rd_ctr[CTR_W-1];

endmodule

// File: rtl/bimodal_predictor_table.sv
// Bimodal branch direction predictor with registered lookup, resolve/update port
// and saturating mispredict counter. Define BP_GSHARE_EN to hash the PC with global history.
module bimodal_predictor_table
    import bp_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int INDEX_W = 6,
    parameter int CTR_W   = 2,
    parameter int GHR_W   = 6,
    parameter int MISS_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [PC_W-1:0]    req_pc,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [INDEX_W-1:0] pred_index,
    input  logic               upd_valid,
    input  logic [INDEX_W-1:0] upd_index,
    input  logic               upd_taken,
    input  logic               upd_pred,
    output logic [MISS_W-1:0]  miss_count,
    input  logic               clr_stats
);

    generate
        if (INDEX_W < 1 || INDEX_W > PC_W - 2) begin : g_bad_index_w
            $error("bimodal_predictor_table: INDEX_W must be in 1..PC_W-2");
        end
        if (CTR_W < MIN_CTR_W || CTR_W > MAX_CTR_W) begin : g_bad_ctr_w
            $error("bimodal_predictor_table: CTR_W must be in 2..4");
        end
        if (GHR_W < 2 || GHR_W > INDEX_W) begin : g_bad_ghr_w
            $error("bimodal_predictor_table: GHR_W must be in 2..INDEX_W");
        end
        if (MISS_W < 1) begin : g_bad_miss_w
            $error("bimodal_predictor_table: MISS_W must be at least 1");
        end
    endgenerate

    logic [INDEX_W-1:0] w_pc_index;
    logic [INDEX_W-1:0] w_lookup_index;
    logic               w_rd_taken;
    logic               w_mispredict;
    logic               w_unused_pc;

    logic               r_pred_valid;
    logic               r_pred_taken;
    logic [INDEX_W-1:0] r_pred_index;
    logic [MISS_W-1:0]  r_miss_count;

    // Bits [1:0] are instruction alignment; upper bits fall outside the index.
    assign w_pc_index  = req_pc[INDEX_W+1:2];
    assign w_unused_pc = ^req_pc;

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] r_ghr;

    // A lookup in the same cycle as a shift hashes with the pre-shift history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ghr <= '0;
        end else if (upd_valid) begin
            r_ghr <= {r_ghr[GHR_W-2:0], upd_taken};
        end
    end

    assign w_lookup_index = w_pc_index ^ INDEX_W'(r_ghr);
`else
    assign w_lookup_index = w_pc_index;
`endif

    bp_counter_table #(
        .INDEX_W (INDEX_W),
        .CTR_W   (CTR_W)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (upd_valid),
        .i_wr_idx   (upd_index),
        .i_wr_taken (upd_taken),
        .i_rd_idx   (w_lookup_index),
        .o_rd_taken (w_rd_taken)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_index <= '0;
        end else begin
            r_pred_valid <= req_valid;
            if (req_valid) begin
                r_pred_taken <= w_rd_taken;
                r_pred_index <= w_lookup_index;
            end
        end
    end

    assign w_mispredict = upd_valid && (upd_pred != upd_taken);

    // Clearing wins over a mispredict in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miss_count <= '0;
        end else if (clr_stats) begin
            r_miss_count <= '0;
        end else if (w_mispredict && !(&r_miss_count)) begin
            r_miss_count <= r_miss_count + MISS_W'(1);
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_index = r_pred_index;
    assign miss_count = r_miss_count;

endmodule

// File: tb/tb_bimodal_predictor_table.sv
// Self-checking bench for bimodal_predictor_table: directed steps then random traffic,
// compared against an array-of-integers model. Honours BP_GSHARE_EN like the design.
module tb_bimodal_predictor_table;

    localparam int PC_W     = 32;
    localparam int INDEX_W  = 6;
    localparam int CTR_W    = 2;
    localparam int GHR_W    = 6;
    localparam int MISS_W   = 4;
    localparam int DEPTH    = 1 << INDEX_W;
    localparam int CTR_MAX  = (1 << CTR_W) - 1;
    localparam int CTR_HALF = 1 << (CTR_W - 1);
    localparam int CTR_INIT = CTR_HALF - 1;
    localparam int MISS_MAX = (1 << MISS_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic [PC_W-1:0]    req_pc;
    logic               pred_valid;
    logic               pred_taken;
    logic [INDEX_W-1:0] pred_index;
    logic               upd_valid;
    logic [INDEX_W-1:0] upd_index;
    logic               upd_taken;
    logic               upd_pred;
    logic [MISS_W-1:0]  miss_count;
    logic               clr_stats;

    always #5 clk = ~clk;

    bimodal_predictor_table #(
        .PC_W    (PC_W),
        .INDEX_W (INDEX_W),
        .CTR_W   (CTR_W),
        .GHR_W   (GHR_W),
        .MISS_W  (MISS_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_index (pred_index),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_taken  (upd_taken),
        .upd_pred   (upd_pred),
        .miss_count (miss_count),
        .clr_stats  (clr_stats)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: plain integers, one per table entry.
    int m_ctr [DEPTH];
    int m_ghr;
    int m_miss;
    int m_valid;
    int m_taken;
    int m_index;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = CTR_INIT;
        m_ghr   = 0;
        m_miss  = 0;
        m_valid = 0;
        m_taken = 0;
        m_index = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, check 1 time unit later.
    task automatic step(input bit rv, input logic [31:0] pc, input bit uv, input int uidx,
                        input bit ut, input bit up, input bit clr);
        int idx;
        int u;
        u         = uidx & (DEPTH - 1);
        req_valid = rv;
        req_pc    = pc;
        upd_valid = uv;
        upd_index = INDEX_W'(u);
        upd_taken = ut;
        upd_pred  = up;
        clr_stats = clr;
        @(posedge clk);
        idx = int'((pc >> 2) & (DEPTH - 1));
`ifdef BP_GSHARE_EN
        idx = idx ^ m_ghr;
`endif
        if (clr) m_miss = 0;
        else if (uv && (up != ut) && (m_miss < MISS_MAX)) m_miss = m_miss + 1;
        if (uv) begin
            if (ut) m_ctr[u] = (m_ctr[u] < CTR_MAX) ? m_ctr[u] + 1 : CTR_MAX;
            else    m_ctr[u] = (m_ctr[u] > 0) ? m_ctr[u] - 1 : 0;
            m_ghr = ((m_ghr << 1) | int'(ut)) & ((1 << GHR_W) - 1);
        end
        m_valid = rv;
        if (rv) begin
            m_taken = (m_ctr[idx] >= CTR_HALF) ? 1 : 0;
            m_index = idx;
        end
        #1;
        $display("step t=%0t rv=%0b pc=%h uv=%0b uidx=%0d ut=%0b up=%0b clr=%0b -> valid=%0b taken=%0b index=%0d miss=%0d",
                 $time, rv, pc, uv, u, ut, up, clr, pred_valid, pred_taken, pred_index, miss_count);
        check("pred_valid", 32'(pred_valid), 32'(m_valid));
        if (m_valid != 0) begin
            check("pred_taken", 32'(pred_taken), 32'(m_taken));
            check("pred_index", 32'(pred_index), 32'(m_index));
        end
        check("miss_count", 32'(miss_count), 32'(m_miss));
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] pc;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        upd_valid = 1'b0;
        upd_index = '0;
        upd_taken = 1'b0;
        upd_pred  = 1'b0;
        clr_stats = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(pred_valid), 32'd0);
        check("reset_taken", 32'(pred_taken), 32'd0);
        check("reset_index", 32'(pred_index), 32'd0);
        check("reset_miss",  32'(miss_count), 32'd0);
        rst_n = 1'b1;

        // First lookup after reset: weakly-not-taken, index from pc[7:2].
        step(1, 32'h100, 0, 0, 0, 0, 0);
        check("first_index", 32'(pred_index), 32'd0);
        check("first_taken", 32'(pred_taken), 32'd0);
        idle();

        // Train index 5 up, then back down.
        step(0, 32'h0, 1, 5, 1, 1, 0);
        step(0, 32'h0, 1, 5, 1, 1, 0);
        step(1, 32'h14, 0, 0, 0, 0, 0);
        step(0, 32'h0, 1, 5, 0, 1, 0);
        step(1, 32'h14, 0, 0, 0, 0, 0);
        step(0, 32'h0, 1, 5, 0, 1, 0);
        step(1, 32'h14, 0, 0, 0, 0, 0);

        // Saturation at the top, then a single step down.
        repeat (5) step(0, 32'h0, 1, 3, 1, 1, 0);
        step(0, 32'h0, 1, 3, 0, 1, 0);
        step(1, 32'hC, 0, 0, 0, 0, 0);
        repeat (3) step(0, 32'h0, 1, 3, 0, 0, 0);
        step(1, 32'hC, 0, 0, 0, 0, 0);

        // Lookup and update on the same index at the same edge.
        step(1, 32'h1C, 1, 7, 1, 1, 0);
        // Back-to-back lookups, one also racing an update to another index.
        step(1, 32'h1C, 1, 8, 1, 1, 0);
        step(1, 32'h20, 0, 0, 0, 0, 0);

        // Mispredict counter.
        step(0, 32'h0, 0, 0, 0, 0, 1);
        repeat (3) step(0, 32'h0, 1, 9, 1, 0, 0);
        check("miss_three", 32'(miss_count), 32'd3);
        step(0, 32'h0, 1, 9, 0, 1, 1);
        check("miss_clr_wins", 32'(miss_count), 32'd0);
        repeat (20) step(0, 32'h0, 1, 10, 0, 1, 0);
        check("miss_saturate", 32'(miss_count), 32'(MISS_MAX));

        // Asynchronous reset mid-stream, away from the clock edge.
        step(1, 32'h14, 1, 5, 1, 0, 0);
        rst_n = 1'b0;
        #2;
        check("async_valid", 32'(pred_valid), 32'd0);
        check("async_taken", 32'(pred_taken), 32'd0);
        check("async_index", 32'(pred_index), 32'd0);
        check("async_miss",  32'(miss_count), 32'd0);
        model_reset();
        #1;
        rst_n = 1'b1;

        // History shaping: two taken updates, then lookup pc=0.
        step(0, 32'h0, 1, 5, 1, 1, 0);
        step(0, 32'h0, 1, 5, 1, 1, 0);
        step(1, 32'h0, 0, 0, 0, 0, 0);
`ifdef BP_GSHARE_EN
        check("hash_index", 32'(pred_index), 32'd3);
`else
        check("hash_index", 32'(pred_index), 32'd0);
`endif

        // Random traffic concentrated on a few indices to force collisions.
        for (int n = 0; n < 400; n++) begin
            pc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            step($urandom_range(0, 3) != 0, pc, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
